// File: rtl/multicycle_ctrl_unit_if.sv
// Handshake and datapath-control bundle between instruction fetch,
// the multicycle control stage and the FullDMRFALU datapath.
interface multicycle_ctrl_unit_if #(
  parameter int PC_WIDTH = 8
);
  logic [31:0]         instr_in;
  logic                instr_valid;
  logic                instr_ready;
  logic [PC_WIDTH-1:0] pc;
  logic                MemWrite;
  logic                MemRead;
  logic                RegWrite;
  logic [5:0]          FuncCode;
  logic [1:0]          ALUOp;
  logic [15:0]         SEin;
  logic [4:0]          A;
  logic [4:0]          B;
  logic [4:0]          wr_addr;
  logic                sel;
  logic                mem_to_reg;
  logic                busy;
  logic                illegal;

  // Fetch side / observer
  modport master (
    output instr_in, instr_valid,
    input  instr_ready, pc, MemWrite, MemRead, RegWrite, FuncCode, ALUOp,
           SEin, A, B, wr_addr, sel, mem_to_reg, busy, illegal
  );

  // Control stage
  modport slave (
    input  instr_in, instr_valid,
    output instr_ready, pc, MemWrite, MemRead, RegWrite, FuncCode, ALUOp,
           SEin, A, B, wr_addr, sel, mem_to_reg, busy, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_unit.sv
// Multicycle control stage: FETCH/DECODE/EXEC/MEM/WB sequencer with pc.
// All strobes and decoded fields are flops, so they are glitch-free Moore
// outputs that line up with the state they belong to.
module multicycle_ctrl_unit #(
  parameter int PC_WIDTH = 8,
  parameter int PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_ctrl_unit_if.slave  bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef struct packed {
    logic [5:0]  func;
    logic [1:0]  alu_op;
    logic [15:0] se_in;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  wr_addr;
    logic        sel;
    logic        mem_to_reg;
  } fields_t;

  state_e              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  fields_t             fld_q, fld_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic                reg_write_q, reg_write_d;
  logic                illegal_q, illegal_d;

  logic                accept;
  logic [5:0]          in_op;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  assign in_op  = bus.instr_in[31:26];
  assign accept = (state_q == FETCH) && bus.instr_valid;

  // Next state, pc, decoded fields and registered strobes
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pc_d        = pc_q;
    fld_d       = fld_q;
    illegal_d   = 1'b0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    reg_write_d = 1'b0;
    case (state_q)
      FETCH: if (accept) begin
        // Fields are decoded straight off the accepted word so they are
        // already stable during DECODE and hold until the next accept.
        op_d              = in_op;
        pc_d              = pc_q + PC_WIDTH'(PC_STEP);
        fld_d.a           = bus.instr_in[25:21];
        fld_d.b           = bus.instr_in[20:16];
        fld_d.wr_addr     = (in_op == OP_R) ? bus.instr_in[15:11] : bus.instr_in[20:16];
        fld_d.func        = bus.instr_in[5:0];
        fld_d.se_in       = bus.instr_in[15:0];
        fld_d.alu_op      = (in_op == OP_R) ? 2'b10 : 2'b00;
        fld_d.sel         = is_legal(in_op) && (in_op != OP_R);
        fld_d.mem_to_reg  = (in_op == OP_LW);
        illegal_d         = !is_legal(in_op);
        state_d           = DECODE;
      end
      DECODE:  state_d = is_legal(op_q) ? EXEC : FETCH;
      EXEC:    state_d = ((op_q == OP_LW) || (op_q == OP_SW)) ? MEM : WB;
      MEM:     state_d = (op_q == OP_LW) ? WB : FETCH;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
    mem_read_d  = (state_d == MEM) && (op_q == OP_LW);
    mem_write_d = (state_d == MEM) && (op_q == OP_SW);
    reg_write_d = (state_d == WB);
  end

  // State and output registers; reset clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      op_q        <= '0;
      pc_q        <= '0;
      fld_q       <= '0;
      illegal_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pc_q        <= pc_d;
      fld_q       <= fld_d;
      illegal_q   <= illegal_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
    end
  end

  // instr_ready is gated by rst so it is low during reset and rises on release
  assign bus.instr_ready = (state_q == FETCH) && !rst;
  assign bus.busy        = (state_q != FETCH);
  assign bus.pc          = pc_q;
  assign bus.MemWrite    = mem_write_q;
  assign bus.MemRead     = mem_read_q;
  assign bus.RegWrite    = reg_write_q;
  assign bus.illegal     = illegal_q;
  assign bus.FuncCode    = fld_q.func;
  assign bus.ALUOp       = fld_q.alu_op;
  assign bus.SEin        = fld_q.se_in;
  assign bus.A           = fld_q.a;
  assign bus.B           = fld_q.b;
  assign bus.wr_addr     = fld_q.wr_addr;
  assign bus.sel         = fld_q.sel;
  assign bus.mem_to_reg  = fld_q.mem_to_reg;
endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: vector table for each opcode
// class plus hand-written reset, idle and streaming sequences.
module tb_multicycle_ctrl_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_unit_if #(.PC_WIDTH(8)) bus ();
  multicycle_ctrl_unit #(.PC_WIDTH(8), .PC_STEP(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] pc_m = 8'h00;

  typedef struct {
    logic [31:0] instr;
    logic        chk_f;
    logic [4:0]  a, b, wr;
    logic [5:0]  func;
    logic [1:0]  alu;
    logic        sel;
    logic [15:0] se;
    logic        m2r;
    int          mr, mw, rw, il, rdy;  // cycle of each pulse (0 = never), ready cycle
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.instr_ready, bus.pc, bus.MemWrite, bus.MemRead, bus.RegWrite,
            bus.FuncCode, bus.ALUOp, bus.SEin, bus.A, bus.B, bus.wr_addr,
            bus.sel, bus.mem_to_reg, bus.busy, bus.illegal};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int mr_c = 0, mw_c = 0, rw_c = 0, il_c = 0, rdy_c = 0, pulses = 0;
    logic m2r_at_rw = 1'b0;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, "_ready_before"}, 64'(bus.instr_ready), 64'd1);
    bus.instr_in    = v.instr;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    pc_m = pc_m + 8'd4;
    for (int k = 1; k <= 8 && rdy_c == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.instr_valid = 1'b0;
        bus.instr_in    = 32'hDEAD_BEEF;
        chk({tag, "_pc"}, 64'(bus.pc), 64'(pc_m));
        if (v.chk_f)
          chk({tag, "_fields"},
              64'({bus.A, bus.B, bus.wr_addr, bus.FuncCode, bus.ALUOp, bus.sel, bus.SEin}),
              64'({v.a, v.b, v.wr, v.func, v.alu, v.sel, v.se}));
      end
      if (bus.MemRead)  begin mr_c = k; pulses++; end
      if (bus.MemWrite) begin mw_c = k; pulses++; end
      if (bus.RegWrite) begin rw_c = k; pulses++; m2r_at_rw = bus.mem_to_reg; end
      if (bus.illegal)  il_c = k;
      if (bus.instr_ready) rdy_c = k;
    end
    chk({tag, "_memread_cyc"},  64'(mr_c),  64'(v.mr));
    chk({tag, "_memwrite_cyc"}, 64'(mw_c),  64'(v.mw));
    chk({tag, "_regwrite_cyc"}, 64'(rw_c),  64'(v.rw));
    chk({tag, "_illegal_cyc"},  64'(il_c),  64'(v.il));
    chk({tag, "_ready_cyc"},    64'(rdy_c), 64'(v.rdy));
    chk({tag, "_strobe_count"}, 64'(pulses), 64'((v.mr != 0) + (v.mw != 0) + (v.rw != 0)));
    if (v.rw != 0) chk({tag, "_mem_to_reg"}, 64'(m2r_at_rw), 64'(v.m2r));
  endtask

  initial begin
    int rw_cnt, acc, cyc;
    logic bad, wrap_seen, done;
    logic [7:0] prev_pc, start_pc;

    //            instr         chk a  b  wr func   alu    sel se        m2r mr mw rw il rdy
    vecs[0] = '{32'h00430820, 1, 2, 3, 1, 6'h20, 2'b10, 0, 16'h0820, 0, 0, 0, 3, 0, 4};
    vecs[1] = '{32'h8C450010, 1, 2, 5, 5, 6'h10, 2'b00, 1, 16'h0010, 1, 3, 0, 4, 0, 5};
    vecs[2] = '{32'hAC45FFFC, 1, 2, 5, 5, 6'h3C, 2'b00, 1, 16'hFFFC, 0, 0, 3, 0, 0, 4};
    vecs[3] = '{32'hFC000000, 0, 0, 0, 0, 6'h00, 2'b00, 0, 16'h0000, 0, 0, 0, 0, 1, 2};
    vecs[4] = '{32'h20238000, 1, 1, 3, 3, 6'h00, 2'b00, 1, 16'h8000, 0, 0, 0, 3, 0, 4};
    vecs[5] = '{32'h01CF8822, 1, 14, 15, 17, 6'h22, 2'b10, 0, 16'h8822, 0, 0, 0, 3, 0, 4};

    bus.instr_in    = '0;
    bus.instr_valid = 1'b0;

    // Reset state
    #1 chk("reset_outputs", all_outs(), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_at_release", 64'(bus.instr_ready), 64'd1);
    chk("pc_after_reset", 64'(bus.pc), 64'd0);

    // Opcode vectors
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset in EXEC of an LW abandons it with no late strobes
    @(negedge clk);
    bus.instr_in = 32'h8C450010; bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.instr_valid = 1'b0;   // DECODE
    @(negedge clk);                           // EXEC
    chk("lw_in_exec_busy", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_exec_outputs", all_outs(), 64'd0);
    pc_m = 8'h00;
    bad = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.MemRead || bus.RegWrite) bad = 1'b1; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.MemRead || bus.RegWrite || bus.MemWrite) bad = 1'b1; end
    chk("no_strobe_after_rst", 64'(bad), 64'd0);
    chk("ready_after_release", 64'(bus.instr_ready), 64'd1);
    chk("pc_zero_after_rst", 64'(bus.pc), 64'd0);

    // Idle in FETCH: everything holds
    run_vec(vecs[0], 10);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.pc !== pc_m || !bus.instr_ready || bus.busy || bus.MemRead ||
          bus.MemWrite || bus.RegWrite || bus.illegal || bus.A !== 5'd2 ||
          bus.wr_addr !== 5'd1 || bus.FuncCode !== 6'h20) bad = 1'b1;
    end
    chk("idle_stable", 64'(bad), 64'd0);

    // 64 back-to-back R-types: pc wraps, exactly 64 RegWrite pulses
    rw_cnt = 0; acc = 0; wrap_seen = 1'b0; done = 1'b0; cyc = 0;
    start_pc = bus.pc; prev_pc = bus.pc;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.RegWrite) rw_cnt++;
      if (prev_pc == 8'hFC && bus.pc == 8'h00) wrap_seen = 1'b1;
      prev_pc = bus.pc;
      if (bus.instr_ready) begin
        if (acc < 64) begin
          bus.instr_in = 32'h00430820; bus.instr_valid = 1'b1; acc++;
        end else begin
          bus.instr_valid = 1'b0; done = 1'b1;
        end
      end
    end
    chk("stream_done", 64'(done), 64'd1);
    chk("stream_regwrites", 64'(rw_cnt), 64'd64);
    chk("stream_pc_wrap", 64'(wrap_seen), 64'd1);
    chk("stream_pc_final", 64'(bus.pc), 64'(start_pc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
